// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with registered ready/valid and NOP fill.
// Optional bubble counter enabled by defining PIPE_BUBBLE_CNT_EN.
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(32'h00000013),
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_stages_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_p1;
    logic [WIDTH-1:0] main_p1;
    logic [WIDTH-1:0] skid_p1;
    logic             accept;
    logic             drain;

    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    // main is forced back to NOP_VALUE whenever it empties, so it can drive out_data directly.
    assign out_data = main_p1;

    // ---- stage p1: occupancy, storage and registered handshake outputs ----
    always_ff @(posedge clk or negedge reset_stages_n) begin
        if (!reset_stages_n) begin
            state_p1  <= EMPTY;
            main_p1   <= NOP_VALUE;
            skid_p1   <= NOP_VALUE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state_p1  <= EMPTY;
            main_p1   <= NOP_VALUE;
            skid_p1   <= NOP_VALUE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        state_p1  <= ONE;
                        main_p1   <= in_data;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, drain})
                        2'b11: main_p1 <= in_data;
                        2'b10: begin
                            state_p1 <= FULL;
                            skid_p1  <= in_data;
                            in_ready <= 1'b0;
                        end
                        2'b01: begin
                            state_p1  <= EMPTY;
                            main_p1   <= NOP_VALUE;
                            out_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // Stall holds both entries; a drain promotes the skid word to the head.
                    if (drain) begin
                        state_p1 <= ONE;
                        main_p1  <= skid_p1;
                        skid_p1  <= NOP_VALUE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state_p1  <= EMPTY;
                    main_p1   <= NOP_VALUE;
                    skid_p1   <= NOP_VALUE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- stage p1: bubble accounting, counts idle or flushed cycles ----
    always_ff @(posedge clk or negedge reset_stages_n) begin
        if (!reset_stages_n) begin
            bubble_cnt <= '0;
        end else if (!out_valid || flush) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end
`endif

endmodule
